// File: rtl/next_pc_unit_pkg.sv
// Shared types and constants for the fetch-path next-PC selection logic.
// The PC width here is the same default that the pc register uses.
package next_pc_unit_pkg;

  localparam int PC_WIDTH             = 14;
  localparam int BTB_ENTRIES_DEFAULT  = 16;
  localparam int BTB_IDX_BITS_DEFAULT = $clog2(BTB_ENTRIES_DEFAULT);

  // Two-bit saturating counter states; bit 1 alone gives the taken prediction.
  localparam logic [1:0] CTR_SNT   = 2'b00;
  localparam logic [1:0] CTR_WNT   = 2'b01;
  localparam logic [1:0] CTR_WT    = 2'b10;
  localparam logic [1:0] CTR_ST    = 2'b11;
  localparam logic [1:0] CTR_ALLOC = CTR_WT;

  typedef struct packed {
    logic                                     valid;
    logic [PC_WIDTH-BTB_IDX_BITS_DEFAULT-1:0] tag;
    logic [PC_WIDTH-1:0]                      target;
    logic [1:0]                               ctr;
  } btb_entry_t;

  function automatic logic [1:0] ctr_inc(input logic [1:0] ctr);
    return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] ctr);
    return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/next_pc_unit_btb_table.sv
// Direct-mapped branch target buffer: async lookup port, one training port,
// and a one-cycle valid-bit clear on reset.
module btb_table
  import next_pc_unit_pkg::*;
#(
  parameter int WIDTH       = PC_WIDTH,
  parameter int BTB_ENTRIES = BTB_ENTRIES_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] rd_pc,
  output logic             rd_hit,
  output logic             rd_taken,
  output logic [WIDTH-1:0] rd_target,
  input  logic             upd_valid,
  input  logic [WIDTH-1:0] upd_pc,
  input  logic             upd_taken,
  input  logic [WIDTH-1:0] upd_target
);

  localparam int IDX_BITS = $clog2(BTB_ENTRIES);
  localparam int TAG_BITS = WIDTH - IDX_BITS;

  // Same field layout as btb_entry_t, sized for this instance's parameters.
  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [WIDTH-1:0]    target;
    logic [1:0]          ctr;
  } entry_t;

  entry_t mem [BTB_ENTRIES];

  logic [IDX_BITS-1:0] rd_idx;
  logic [TAG_BITS-1:0] rd_tag;
  entry_t              rd_entry;

  logic [IDX_BITS-1:0] upd_idx;
  logic [TAG_BITS-1:0] upd_tag;
  entry_t              upd_entry;
  logic                upd_hit;
  logic                wr_en;
  entry_t              wr_entry;

  assign rd_idx   = rd_pc[IDX_BITS-1:0];
  assign rd_tag   = rd_pc[WIDTH-1:IDX_BITS];
  assign rd_entry = mem[rd_idx];

  assign rd_hit    = rd_entry.valid && (rd_entry.tag == rd_tag);
  assign rd_taken  = rd_hit && rd_entry.ctr[1];
  assign rd_target = rd_hit ? rd_entry.target : '0;

  assign upd_idx   = upd_pc[IDX_BITS-1:0];
  assign upd_tag   = upd_pc[WIDTH-1:IDX_BITS];
  assign upd_entry = mem[upd_idx];
  assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

  // Resolved branches train hits in place; a taken miss evicts whatever
  // shares its index, while a not-taken miss is not worth a slot.
  always_comb begin
    wr_en    = 1'b0;
    wr_entry = upd_entry;
    if (upd_valid) begin
      if (upd_hit) begin
        wr_en = 1'b1;
        if (upd_taken) begin
          wr_entry.ctr    = ctr_inc(upd_entry.ctr);
          wr_entry.target = upd_target;
        end else begin
          wr_entry.ctr = ctr_dec(upd_entry.ctr);
        end
      end else if (upd_taken) begin
        wr_en           = 1'b1;
        wr_entry.valid  = 1'b1;
        wr_entry.tag    = upd_tag;
        wr_entry.target = upd_target;
        wr_entry.ctr    = CTR_ALLOC;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        mem[i].valid <= 1'b0;
      end
    end else if (wr_en) begin
      mem[upd_idx] <= wr_entry;
    end
  end

endmodule

// File: rtl/next_pc_unit.sv
// Next-PC select for the fetch path: redirect > stall > BTB prediction > PC+1.
// Output feeds the pc register input directly, with no added latency.
module next_pc_unit
  import next_pc_unit_pkg::*;
#(
  parameter int WIDTH       = PC_WIDTH,
  parameter int BTB_ENTRIES = BTB_ENTRIES_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_pc,
  input  logic             i_stall,
  input  logic             i_redirect_valid,
  input  logic [WIDTH-1:0] i_redirect_pc,
  input  logic             i_upd_valid,
  input  logic [WIDTH-1:0] i_upd_pc,
  input  logic             i_upd_taken,
  input  logic [WIDTH-1:0] i_upd_target,
  output logic [WIDTH-1:0] o_next_pc,
  output logic             o_pred_taken,
  output logic [WIDTH-1:0] o_pred_target
);

  logic             btb_hit;
  logic             btb_taken;
  logic [WIDTH-1:0] btb_target;
  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] next_pc;
  logic             pred_taken;

  btb_table #(
    .WIDTH       (WIDTH),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .rd_pc      (i_pc),
    .rd_hit     (btb_hit),
    .rd_taken   (btb_taken),
    .rd_target  (btb_target),
    .upd_valid  (i_upd_valid),
    .upd_pc     (i_upd_pc),
    .upd_taken  (i_upd_taken),
    .upd_target (i_upd_target)
  );

  assign seq_pc = i_pc + WIDTH'(1);

  // A prediction is only reported when it actually steers fetch, so EX never
  // sees a taken prediction for a cycle that was squashed or held.
  always_comb begin
    next_pc    = seq_pc;
    pred_taken = 1'b0;
    if (i_rst) begin
      next_pc = '0;
    end else if (i_redirect_valid) begin
      next_pc = i_redirect_pc;
    end else if (i_stall) begin
      next_pc = i_pc;
    end else if (btb_taken) begin
      next_pc    = btb_target;
      pred_taken = 1'b1;
    end
  end

  assign o_next_pc     = next_pc;
  assign o_pred_taken  = pred_taken;
  assign o_pred_target = btb_hit ? btb_target : '0;

endmodule

// File: tb/tb_next_pc_unit.sv
// Scoreboard bench for next_pc_unit: each cycle's expected outputs are queued
// as the stimulus is driven and compared on the following falling edge.
module tb_next_pc_unit;

  localparam int W = 14;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] pc;
  logic         stall;
  logic         rv;
  logic [W-1:0] rpc;
  logic         uv;
  logic [W-1:0] upc;
  logic         ut;
  logic [W-1:0] utgt;
  logic [W-1:0] next_pc;
  logic         pred_taken;
  logic [W-1:0] pred_target;

  typedef struct {
    string        name;
    logic [W-1:0] next_pc;
    logic         taken;
    logic [W-1:0] target;
    bit           chk_tgt;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  next_pc_unit dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_pc             (pc),
    .i_stall          (stall),
    .i_redirect_valid (rv),
    .i_redirect_pc    (rpc),
    .i_upd_valid      (uv),
    .i_upd_pc         (upc),
    .i_upd_taken      (ut),
    .i_upd_target     (utgt),
    .o_next_pc        (next_pc),
    .o_pred_taken     (pred_taken),
    .o_pred_target    (pred_target)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    else
      passed++;
  endtask

  // Drive one cycle of inputs just after the rising edge, queue the expected
  // outputs, then pop and compare them on the falling edge.
  task automatic applyStimulus(input string name, input logic r,
                               input logic [W-1:0] p, input logic s,
                               input logic rvv, input logic [W-1:0] rp,
                               input logic u, input logic [W-1:0] up,
                               input logic t, input logic [W-1:0] tg,
                               input logic [W-1:0] e_next, input logic e_taken,
                               input logic [W-1:0] e_tgt, input bit chk_tgt);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; pc = p; stall = s; rv = rvv; rpc = rp;
    uv = u; upc = up; ut = t; utgt = tg;
    e.name = name; e.next_pc = e_next; e.taken = e_taken;
    e.target = e_tgt; e.chk_tgt = chk_tgt;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      checkOutput({e.name, ".next_pc"}, 32'(next_pc), 32'(e.next_pc));
      checkOutput({e.name, ".pred_taken"}, 32'(pred_taken), 32'(e.taken));
      if (e.chk_tgt)
        checkOutput({e.name, ".pred_target"}, 32'(pred_target), 32'(e.target));
    end
  endtask

  initial begin
    rst = 1'b1; pc = '0; stall = 1'b0; rv = 1'b0; rpc = '0;
    uv = 1'b0; upc = '0; ut = 1'b0; utgt = '0;

    //            name          rst pc       st rv rpc      uv upc      ut utgt     next     tk tgt      chk
    applyStimulus("rst0",       1, 14'h0005, 0, 0, 14'h0000, 0, 14'h0000, 0, 14'h0000, 14'h0000, 0, 14'h0000, 0);
    applyStimulus("rst_upd",    1, 14'h0005, 0, 0, 14'h0000, 1, 14'h0005, 1, 14'h0050, 14'h0000, 0, 14'h0000, 0);
    applyStimulus("release",    0, 14'h0005, 0, 0, 14'h0000, 0, 14'h0000, 0, 14'h0000, 14'h0006, 0, 14'h0000, 1);
    applyStimulus("wrap",       0, 14'h3FFF, 0, 0, 14'h0000, 0, 14'h0000, 0, 14'h0000, 14'h0000, 0, 14'h0000, 1);

    applyStimulus("alloc",      0, 14'h0012, 0, 0, 14'h0000, 1, 14'h0012, 1, 14'h0100, 14'h0013, 0, 14'h0000, 1);
    applyStimulus("alloc_vis",  0, 14'h0012, 0, 0, 14'h0000, 0, 14'h0000, 0, 14'h0000, 14'h0100, 1, 14'h0100, 1);
    applyStimulus("decay_nt",   0, 14'h0012, 0, 0, 14'h0000, 1, 14'h0012, 0, 14'h0000, 14'h0100, 1, 14'h0100, 1);
    applyStimulus("decay_vis",  0, 14'h0012, 0, 0, 14'h0000, 0, 14'h0000, 0, 14'h0000, 14'h0013, 0, 14'h0100, 1);

    applyStimulus("sat_t1",     0, 14'h0012, 0, 0, 14'h0000, 1, 14'h0012, 1, 14'h0100, 14'h0013, 0, 14'h0100, 1);
    applyStimulus("sat_t2",     0, 14'h0012, 0, 0, 14'h0000, 1, 14'h0012, 1, 14'h0100, 14'h0100, 1, 14'h0100, 1);
    applyStimulus("sat_t3",     0, 14'h0012, 0, 0, 14'h0000, 1, 14'h0012, 1, 14'h0100, 14'h0100, 1, 14'h0100, 1);
    applyStimulus("sat_nt1",    0, 14'h0012, 0, 0, 14'h0000, 1, 14'h0012, 0, 14'h0000, 14'h0100, 1, 14'h0100, 1);
    applyStimulus("sat_hold",   0, 14'h0012, 0, 0, 14'h0000, 0, 14'h0000, 0, 14'h0000, 14'h0100, 1, 14'h0100, 1);
    applyStimulus("sat_nt2",    0, 14'h0012, 0, 0, 14'h0000, 1, 14'h0012, 0, 14'h0000, 14'h0100, 1, 14'h0100, 1);
    applyStimulus("sat_nt_vis", 0, 14'h0012, 0, 0, 14'h0000, 0, 14'h0000, 0, 14'h0000, 14'h0013, 0, 14'h0100, 1);
    applyStimulus("retarget",   0, 14'h0012, 0, 0, 14'h0000, 1, 14'h0012, 1, 14'h0200, 14'h0013, 0, 14'h0100, 1);
    applyStimulus("retgt_vis",  0, 14'h0012, 0, 0, 14'h0000, 0, 14'h0000, 0, 14'h0000, 14'h0200, 1, 14'h0200, 1);

    applyStimulus("floor_nt1",  0, 14'h0012, 0, 0, 14'h0000, 1, 14'h0012, 0, 14'h0000, 14'h0200, 1, 14'h0200, 1);
    applyStimulus("floor_nt2",  0, 14'h0012, 0, 0, 14'h0000, 1, 14'h0012, 0, 14'h0000, 14'h0013, 0, 14'h0200, 1);
    applyStimulus("floor_nt3",  0, 14'h0012, 0, 0, 14'h0000, 1, 14'h0012, 0, 14'h0000, 14'h0013, 0, 14'h0200, 1);
    applyStimulus("floor_t1",   0, 14'h0012, 0, 0, 14'h0000, 1, 14'h0012, 1, 14'h0200, 14'h0013, 0, 14'h0200, 1);
    applyStimulus("floor_vis",  0, 14'h0012, 0, 0, 14'h0000, 0, 14'h0000, 0, 14'h0000, 14'h0013, 0, 14'h0200, 1);
    applyStimulus("floor_t2",   0, 14'h0012, 0, 0, 14'h0000, 1, 14'h0012, 1, 14'h0200, 14'h0013, 0, 14'h0200, 1);
    applyStimulus("floor_vis2", 0, 14'h0012, 0, 0, 14'h0000, 0, 14'h0000, 0, 14'h0000, 14'h0200, 1, 14'h0200, 1);

    applyStimulus("alias_miss", 0, 14'h0022, 0, 0, 14'h0000, 0, 14'h0000, 0, 14'h0000, 14'h0023, 0, 14'h0000, 1);
    applyStimulus("same_cycle", 0, 14'h0022, 0, 0, 14'h0000, 1, 14'h0022, 1, 14'h0300, 14'h0023, 0, 14'h0000, 1);
    applyStimulus("alias_vis",  0, 14'h0022, 0, 0, 14'h0000, 0, 14'h0000, 0, 14'h0000, 14'h0300, 1, 14'h0300, 1);
    applyStimulus("evicted",    0, 14'h0012, 0, 0, 14'h0000, 0, 14'h0000, 0, 14'h0000, 14'h0013, 0, 14'h0000, 1);
    applyStimulus("miss_nt",    0, 14'h0022, 0, 0, 14'h0000, 1, 14'h0032, 0, 14'h0000, 14'h0300, 1, 14'h0300, 1);
    applyStimulus("miss_nt_vis",0, 14'h0022, 0, 0, 14'h0000, 0, 14'h0000, 0, 14'h0000, 14'h0300, 1, 14'h0300, 1);

    applyStimulus("stall_redir",0, 14'h0022, 1, 1, 14'h0200, 0, 14'h0000, 0, 14'h0000, 14'h0200, 0, 14'h0300, 1);
    applyStimulus("stall_only", 0, 14'h0022, 1, 0, 14'h0000, 0, 14'h0000, 0, 14'h0000, 14'h0022, 0, 14'h0300, 1);
    applyStimulus("redir_only", 0, 14'h0022, 0, 1, 14'h0250, 0, 14'h0000, 0, 14'h0000, 14'h0250, 0, 14'h0300, 1);
    applyStimulus("neither",    0, 14'h0022, 0, 0, 14'h0000, 0, 14'h0000, 0, 14'h0000, 14'h0300, 1, 14'h0300, 1);
    applyStimulus("train_stall",0, 14'h0022, 1, 0, 14'h0000, 1, 14'h0022, 0, 14'h0000, 14'h0022, 0, 14'h0300, 1);
    applyStimulus("after_stall",0, 14'h0022, 0, 0, 14'h0000, 0, 14'h0000, 0, 14'h0000, 14'h0023, 0, 14'h0300, 1);
    applyStimulus("train_redir",0, 14'h0022, 0, 1, 14'h0040, 1, 14'h0022, 1, 14'h0300, 14'h0040, 0, 14'h0300, 1);
    applyStimulus("after_redir",0, 14'h0022, 0, 0, 14'h0000, 0, 14'h0000, 0, 14'h0000, 14'h0300, 1, 14'h0300, 1);

    applyStimulus("mid_rst",    1, 14'h0022, 0, 0, 14'h0000, 0, 14'h0000, 0, 14'h0000, 14'h0000, 0, 14'h0000, 0);
    applyStimulus("post_rst",   0, 14'h0022, 0, 0, 14'h0000, 0, 14'h0000, 0, 14'h0000, 14'h0023, 0, 14'h0000, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
